// File: rtl/store_pkg.sv
// Shared opcode, funct3 and state definitions for the store sequencer
// and its lane-alignment helper.
package store_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/store_align.sv
// Combinational byte-lane steering for stores: byte enables, replicated
// write data, misalignment and unsupported-width detection.
module store_align
    import store_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [2:0]      funct3,
    input  logic [OW-1:0]   offset,
    input  logic [XLEN-1:0] rs2,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] wdata,
    output logic            misalign,
    output logic            illegal_f3
);

    logic [2:0] off3;

    // Narrow stores replicate their data into every lane so the memory only
    // has to honour the byte enables.
    always_comb begin
        off3       = 3'(offset);
        be         = '0;
        wdata      = '0;
        misalign   = 1'b0;
        illegal_f3 = 1'b0;
        case (funct3)
            F3_SB: begin
                be    = NB'(1) << offset;
                wdata = {NB{rs2[7:0]}};
            end
            F3_SH: begin
                be       = NB'(2'b11) << offset;
                wdata    = {(NB/2){rs2[15:0]}};
                misalign = off3[0];
            end
            F3_SW: begin
                be       = NB'(4'hF) << offset;
                wdata    = {(NB/4){rs2[31:0]}};
                misalign = (off3[1:0] != 2'b00);
            end
            F3_SD: begin
                if (XLEN == 64) begin
                    be       = '1;
                    wdata    = rs2;
                    misalign = (off3 != 3'b000);
                end else begin
                    illegal_f3 = 1'b1;
                end
            end
            default: illegal_f3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_sequencer.sv
// Sequences one store through a request/ready memory handshake and raises
// done or a single fault pulse; the core stalls while busy is high.
module store_sequencer
    import store_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] eff_addr,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [NB-1:0]   mem_be,
    output logic            addr_sel,
    output logic            sub_sra,
    output logic            pc_next_sel,
    output logic            pc_alu_sel,
    output logic            rd_we,
    output logic            busy,
    output logic            done,
    output logic            misalign,
    output logic            timeout,
    output logic            illegal
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state, state_next;
    logic [CW-1:0]   counter, counter_next;
    logic            req_next, addr_sel_next, busy_next;
    logic            done_next, misalign_next, timeout_next, illegal_next;
    logic [XLEN-1:0] addr_next, wdata_next;
    logic [NB-1:0]   be_next;

    logic [NB-1:0]   al_be;
    logic [XLEN-1:0] al_wdata;
    logic            al_misalign, al_illegal;
    logic            unused_insn_bits;

    assign unused_insn_bits = ^{insn[31:15], insn[11:7]};

    store_align #(.XLEN(XLEN)) u_align (
        .funct3     (insn[14:12]),
        .offset     (eff_addr[OW-1:0]),
        .rs2        (rs2_data),
        .be         (al_be),
        .wdata      (al_wdata),
        .misalign   (al_misalign),
        .illegal_f3 (al_illegal)
    );

    assign mem_we      = mem_req;
    assign sub_sra     = 1'b0;
    assign pc_next_sel = 1'b0;
    assign pc_alu_sel  = 1'b0;
    assign rd_we       = 1'b0;

    // Next-state and next-output logic; every visible output is a flop, so
    // each pulse is computed one cycle ahead of the state it belongs to.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        req_next      = mem_req;
        addr_sel_next = addr_sel;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        be_next       = mem_be;
        done_next     = 1'b0;
        misalign_next = 1'b0;
        timeout_next  = 1'b0;
        illegal_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (insn[6:0] != OPC_STORE || al_illegal) begin
                        illegal_next = 1'b1;
                    end else if (al_misalign) begin
                        state_next    = FAULT;
                        misalign_next = 1'b1;
                    end else begin
                        state_next    = REQ;
                        counter_next  = '0;
                        req_next      = 1'b1;
                        addr_sel_next = 1'b1;
                        addr_next     = {eff_addr[XLEN-1:OW], OW'(0)};
                        wdata_next    = al_wdata;
                        be_next       = al_be;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_next    = DONE;
                    done_next     = 1'b1;
                    req_next      = 1'b0;
                    addr_sel_next = 1'b0;
                end else if (TIMEOUT > 0 && counter == CW'(TIMEOUT - 1)) begin
                    state_next    = FAULT;
                    timeout_next  = 1'b1;
                    req_next      = 1'b0;
                    addr_sel_next = 1'b0;
                end else if (counter != {CW{1'b1}}) begin
                    counter_next = counter + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // Reset aborts any in-flight store silently: no done and no fault pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            mem_req   <= 1'b0;
            addr_sel  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            mem_req   <= req_next;
            addr_sel  <= addr_sel_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            mem_be    <= be_next;
            busy      <= busy_next;
            done      <= done_next;
            misalign  <= misalign_next;
            timeout   <= timeout_next;
            illegal   <= illegal_next;
        end
    end

endmodule

// File: tb/tb_store_sequencer.sv
// Drives a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=16) store sequencer with
// the same stimulus and checks both against a transaction-level model.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] insn;
    logic [63:0] eff_addr;
    logic [63:0] rs2_data;
    logic        mem_ready;

    logic        req32, we32, asel32, sub32, pcn32, pca32, rdwe32;
    logic        busy32, done32, mis32, to32, ill32;
    logic [31:0] addr32, wdata32;
    logic [3:0]  be32;

    logic        req64, we64, asel64, sub64, pcn64, pca64, rdwe64;
    logic        busy64, done64, mis64, to64, ill64;
    logic [63:0] addr64, wdata64;
    logic [7:0]  be64;

    int errors = 0;
    int checks = 0;

    string nm [11] = '{"mem_req", "mem_we", "busy", "done", "misalign", "timeout",
                       "illegal", "addr_sel", "mem_addr", "mem_be", "mem_wdata"};

    always #5 clk = ~clk;

    store_sequencer #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .start(start), .insn(insn),
        .eff_addr(eff_addr[31:0]), .rs2_data(rs2_data[31:0]), .mem_ready(mem_ready),
        .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
        .mem_be(be32), .addr_sel(asel32), .sub_sra(sub32), .pc_next_sel(pcn32),
        .pc_alu_sel(pca32), .rd_we(rdwe32), .busy(busy32), .done(done32),
        .misalign(mis32), .timeout(to32), .illegal(ill32)
    );

    store_sequencer #(.XLEN(64), .TIMEOUT(16)) dut64 (
        .clk(clk), .reset(reset), .start(start), .insn(insn),
        .eff_addr(eff_addr), .rs2_data(rs2_data), .mem_ready(mem_ready),
        .mem_req(req64), .mem_we(we64), .mem_addr(addr64), .mem_wdata(wdata64),
        .mem_be(be64), .addr_sel(asel64), .sub_sra(sub64), .pc_next_sel(pcn64),
        .pc_alu_sel(pca64), .rd_we(rdwe64), .busy(busy64), .done(done64),
        .misalign(mis64), .timeout(to64), .illegal(ill64)
    );

    function automatic logic [63:0] obs(input int d, input int k);
        logic [63:0] v;
        v = '0;
        case (k)
            0:  v = 64'(d ? req64   : req32);
            1:  v = 64'(d ? we64    : we32);
            2:  v = 64'(d ? busy64  : busy32);
            3:  v = 64'(d ? done64  : done32);
            4:  v = 64'(d ? mis64   : mis32);
            5:  v = 64'(d ? to64    : to32);
            6:  v = 64'(d ? ill64   : ill32);
            7:  v = 64'(d ? asel64  : asel32);
            8:  v = d ? addr64  : 64'(addr32);
            9:  v = d ? 64'(be64) : 64'(be32);
            10: v = d ? wdata64 : 64'(wdata32);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store transaction. w = cycles mem_ready stays low once the request
    // is up; restart pulses a second start while the stores are in flight.
    task automatic applyStimulus(input string name, input logic [31:0] ins,
                                 input logic [63:0] addr, input logic [63:0] data,
                                 input int w, input bit restart);
        int          cls [2];
        int          n   [2];
        bit          got [2];
        logic [63:0] eaddr [2];
        logic [63:0] ewd   [2];
        logic [63:0] ebe   [2];
        logic [63:0] e     [11];
        int          xl, tmo, nb, size, off, len;
        logic [2:0]  f3;
        bit          both_ok;

        f3 = ins[14:12];
        for (int d = 0; d < 2; d++) begin
            xl  = d ? 64 : 32;
            tmo = d ? 16 : 4;
            nb  = xl / 8;
            ebe[d] = '0; ewd[d] = '0; eaddr[d] = '0;
            n[d] = 0; got[d] = 1'b0;
            if (ins[6:0] != 7'b0100011 || f3 > 3'd3 || (f3 == 3'd3 && xl == 32)) begin
                cls[d] = 0;
            end else begin
                size = 1 << f3;
                off  = int'(addr[2:0]) % nb;
                cls[d] = ((off % size) != 0) ? 1 : 2;
                for (int j = 0; j < nb; j++) begin
                    if (j >= off && j < off + size) ebe[d][j] = 1'b1;
                    ewd[d][j*8 +: 8] = data[(j % size)*8 +: 8];
                end
                eaddr[d] = addr - 64'(off);
                if (xl == 32) eaddr[d][63:32] = '0;
                got[d] = (w < tmo);
                n[d]   = got[d] ? w + 1 : tmo;
            end
        end
        both_ok = (cls[0] == 2) && (cls[1] == 2);

        insn      = ins;
        eff_addr  = addr;
        rs2_data  = data;
        start     = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        tick();
        start    = 1'b0;
        insn     = $urandom;
        eff_addr = {$urandom, $urandom};
        rs2_data = {$urandom, $urandom};

        len = ((w > 17) ? 17 : w) + 4;
        for (int i = 1; i <= len; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 11; k++) e[k] = '0;
                case (cls[d])
                    0: e[6] = 64'(i == 1);
                    1: begin
                        e[4] = 64'(i == 1);
                        e[2] = 64'(i == 1);
                    end
                    default: begin
                        e[0] = 64'(i <= n[d]);
                        e[1] = e[0];
                        e[7] = e[0];
                        e[2] = 64'(i <= n[d] + 1);
                        e[3] = 64'(i == n[d] + 1 && got[d]);
                        e[5] = 64'(i == n[d] + 1 && !got[d]);
                        e[8] = eaddr[d];
                        e[9] = ebe[d];
                        e[10] = ewd[d];
                    end
                endcase
                for (int k = 0; k < 11; k++)
                    if (k < 8 || e[0] == 64'd1)
                        checkOutput($sformatf("%s x%0d c%0d %s", name, d ? 64 : 32, i, nm[k]),
                                    obs(d, k), e[k]);
            end
            mem_ready = (i > w);
            if (restart && both_ok && i == 2) begin
                start = 1'b1;
                insn  = 32'h0020_2023;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] rins;
        logic [63:0] raddr;
        int          rw;

        reset     = 1'b1;
        start     = 1'b0;
        insn      = '0;
        eff_addr  = '0;
        rs2_data  = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 11; k++)
                checkOutput($sformatf("reset x%0d %s", d ? 64 : 32, nm[k]), obs(d, k), '0);
        checkOutput("const sub_sra",     64'({sub32, sub64}), '0);
        checkOutput("const pc_next_sel", 64'({pcn32, pcn64}), '0);
        checkOutput("const pc_alu_sel",  64'({pca32, pca64}), '0);
        checkOutput("const rd_we",       64'({rdwe32, rdwe64}), '0);

        applyStimulus("sb_ready",  32'h0000_0023, 64'h1003, 64'hAABB_CCDD, 0, 1'b0);
        applyStimulus("sh_wait3",  32'h0000_1023, 64'h2002, 64'h1234_ABCD, 3, 1'b1);
        applyStimulus("sw_mis",    32'h0000_2023, 64'h3001, 64'h5555_6666, 0, 1'b0);
        applyStimulus("sw_tmo",    32'h0000_2023, 64'h3000, 64'h0BAD_F00D, 30, 1'b0);
        applyStimulus("alu_op",    32'h0000_0033, 64'h4000, 64'h1, 0, 1'b0);
        applyStimulus("sd_08",     32'h0000_3023, 64'h0000_0000_8000_0008,
                      64'h0123_4567_89AB_CDEF, 1, 1'b0);
        applyStimulus("sw_hi",     32'h0000_2023, 64'h0000_0000_0000_5004,
                      64'hCAFE_BABE_DEAD_BEEF, 2, 1'b0);

        // Reset in the middle of a request aborts it silently.
        insn      = 32'h0000_2023;
        eff_addr  = 64'h6000;
        rs2_data  = 64'h7777_8888;
        start     = 1'b1;
        mem_ready = 1'b0;
        tick();
        start = 1'b0;
        checkOutput("rst_mid x32 mem_req before", 64'(req32), 64'd1);
        checkOutput("rst_mid x64 mem_req before", 64'(req64), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 11; k++)
                checkOutput($sformatf("rst_mid x%0d %s", d ? 64 : 32, nm[k]), obs(d, k), '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst_after c%0d pulses", i),
                        64'({done32, done64, to32, to64, mis32, mis64, busy32, busy64}), '0);
        end

        for (int t = 0; t < 40; t++) begin
            rins        = $urandom;
            rins[14:12] = 3'($urandom_range(0, 7));
            rins[6:0]   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'b0100011;
            raddr       = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) raddr[2:0] = 3'b000;
            rw = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
            applyStimulus($sformatf("rnd%0d", t), rins, raddr, {$urandom, $urandom},
                          rw, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
- Parametrised successor to the combinational S-type decoder.
- Sequences RISC-V store instructions (SB/SH/SW, plus SD when XLEN=64) through a registered request/ready memory handshake.
- Generates byte enables, lane-aligned write data, misalignment and timeout faults, and the datapath control lines (addr_sel, sub_sra, pc_next_sel, pc_alu_sel, rd_we).
- Sits between the top-level control FSM and the data-memory port; the processor stalls while busy=1.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64. NB = XLEN/8 byte lanes; OW = log2(NB) offset bits.
- TIMEOUT, 16: maximum cycles in REQ waiting for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  processor clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse: insn/eff_addr/rs2_data are valid.
- insn  in  32  instruction word.
- eff_addr  in  XLEN  ALU result rs1+imm.
- rs2_data  in  XLEN  store source.
- mem_ready  in  1  memory accepted the write.
- mem_req  out  1  write request.
- mem_we  out  1  write enable (equals mem_req).
- mem_addr  out  XLEN  eff_addr with low OW bits cleared.
- mem_wdata  out  XLEN  lane-replicated data.
- mem_be  out  NB  byte enables.
- addr_sel  out  1  1 = memory address from ALU, 0 = from PC.
- sub_sra  out  1  constant 0 (ALU adds).
- pc_next_sel  out  1  constant 0 (PC+4).
- pc_alu_sel  out  1  constant 0.
- rd_we  out  1  constant 0 (stores never write rd).
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse on successful store.
- misalign  out  1  1-cycle fault pulse.
- timeout  out  1  1-cycle fault pulse.
- illegal  out  1  1-cycle pulse for a non-store opcode or bad funct3.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, counter=0. On the reset edge, all outputs and latched addr/data/be go to 0, including mid-transaction; no done or fault pulse is issued for the aborted store.
- States: IDLE, REQ, DONE, FAULT.
- IDLE, start=1:
  - opcode != 7'b0100011, or funct3 not in {000,001,010} (plus 011 only when XLEN=64) -> stay IDLE; illegal pulses next cycle.
  - Misaligned (SH with addr[0]=1; SW with addr[1:0]!=0; SD with addr[2:0]!=0) -> FAULT; no mem_req is ever asserted.
  - Otherwise -> REQ. On the same edge, latch mem_addr/mem_wdata/mem_be and set mem_req=mem_we=addr_sel=1.
- start while busy is ignored and does not queue.
- REQ:
  - mem_req and all latched values are held stable until mem_ready=1 is sampled.
  - mem_ready=1 -> DONE; on that edge mem_req and addr_sel drop to 0.
  - Otherwise counter increments. Reaching TIMEOUT-1 without ready (TIMEOUT>0) -> FAULT with timeout=1.
  - mem_ready and the timeout limit in the same cycle: ready wins.
- DONE: done=1 for one cycle -> IDLE.
- FAULT: exactly one of misalign/timeout is 1 for one cycle -> IDLE.
- mem_ready outside REQ is ignored.
- Latency:
  - start at cycle 0 -> mem_req from cycle 1.
  - Ready sampled at cycle n -> done at cycle n+1.
  - Minimum start-to-done is 2 cycles.
- Lane rules, with off = eff_addr[OW-1:0]:
  - SB: be = 1<<off; wdata = rs2[7:0] replicated NB times.
  - SH: be = 2'b11<<off; wdata = rs2[15:0] replicated.
  - SW: be = 4'hF<<off; wdata = rs2[31:0] replicated.
  - SD: be all ones; wdata = rs2.
- Counter width is clog2(TIMEOUT+1) and saturates; it is cleared on entry to REQ.

Decomposition:
- Package store_pkg holds:
  - OPC_STORE = 7'b0100011
  - F3_SB/F3_SH/F3_SW/F3_SD
  - state enum {IDLE, REQ, DONE, FAULT}
- One combinational sub-module, store_align: inputs funct3, offset, rs2 -> outputs be, wdata, misalign, illegal_f3. It is reused by a future load sequencer.

Test Plan:
- SB at eff_addr=0x1003, rs2=0xAABBCCDD, mem_ready tied 1 -> mem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, mem_req cycle 1, done cycle 2.
- SH at 0x2002, rs2=0x1234ABCD, mem_ready after 3 wait cycles -> be=4'b1100, wdata=0xABCDABCD; mem_req and data stable through waits; done one cycle after ready.
- SW at 0x3001 -> misalign pulse cycle 1, mem_req never asserted, busy high for one cycle only.
- TIMEOUT=4, mem_ready held 0 -> timeout pulse after 4 REQ cycles, then IDLE, no done.
- start with insn opcode 0110011 -> illegal pulse, state stays IDLE; second start during REQ is ignored.
- reset asserted in REQ cycle 2 -> next edge mem_req=0, busy=0, no done; XLEN=64 SD at 0x..08 -> be=8'hFF.
